// File: rtl/keccak_squeeze.sv
`timescale 1ns/1ps
// ============================================================================
// keccak_squeeze
// ----------------------------------------------------------------------------
// Purpose:
//    Reader end of the Keccak-f[1600] datapath. This block captures a permuted
//    1600-bit state and streams its rate lanes out as 64-bit words on a
//    valid/ready interface. When a block's rate lanes are used up and more
//    words are still owed, it requests another permutation.
//    Rate is 21 lanes for SHAKE128 (mode=0) and 17 lanes for SHAKE256 (mode=1).
//
// Ports:
//    clk        in   1      rising-edge clock
//    rst        in   1      asynchronous, active-low reset
//    start      in   1      pulse: begin squeeze, samples mode and len_words
//    mode       in   1      0 = SHAKE128, 1 = SHAKE256
//    len_words  in   LEN_W  number of 64-bit words to emit
//    perm_req   out  1      pulse: run one permutation
//    perm_done  in   1      pulse: state_in holds a freshly permuted state
//    state_in   in   1600   permuted state, lane i at bits [64*i +: 64]
//    out_data   out  LANE_W squeezed lane
//    out_valid  out  1      out_data valid
//    out_ready  in   1      consumer accepts the word
//    out_last   out  1      marks the final word of the request
//    busy       out  1      high outside IDLE
//    done       out  1      pulse after the last word is accepted
//
// Configuration macro:
//    KECCAK_SQZ_PREFETCH_EN - adds a pending state buffer so the next
//    permutation runs while the current block is emitted, removing the
//    bubble at block boundaries.
// ============================================================================
module keccak_squeeze #(
   parameter int LANE_W = 64,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [LEN_W-1:0]  len_words,
   output logic              perm_req,
   input  logic              perm_done,
   input  logic [1599:0]     state_in,
   output logic [LANE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, WAIT_PERM, EMIT, FIN} state_t;

   localparam logic [4:0] RATE_128 = 5'd21;
   localparam logic [4:0] RATE_256 = 5'd17;

   state_t              state, state_n;
   logic [4:0]          rate, rate_n;
   logic [4:0]          idx, idx_n, idx_inc;
   logic [LEN_W-1:0]    rem, rem_n, rem_dec;
   logic                perm_req_n;
   logic [LANE_W-1:0]   data_n;
   logic                last_n;
   logic                load_buf;
   logic [1599:0]       state_buf;

`ifdef KECCAK_SQZ_PREFETCH_EN
   logic [1599:0]       pend_buf;
   logic                pend_valid, pend_valid_n;
   logic                pend_load;
   logic                buf_from_pend;
   logic                outstanding, outstanding_n;
`endif

   function automatic logic [LANE_W-1:0] lane_sel(input logic [1599:0] s, input logic [4:0] i);
      return s[int'(i)*LANE_W +: LANE_W];
   endfunction

   assign out_valid = (state == EMIT);
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Next-state logic plus the next values of every registered output and
   // counter. out_data/out_last are precomputed here so they sit in flops and
   // hold steady while the consumer stalls.
   always_comb begin
      state_n    = state;
      rate_n     = rate;
      rem_n      = rem;
      idx_n      = idx;
      perm_req_n = 1'b0;
      data_n     = out_data;
      last_n     = out_last;
      load_buf   = 1'b0;
      idx_inc    = idx + 5'd1;
      rem_dec    = rem - LEN_W'(1);
`ifdef KECCAK_SQZ_PREFETCH_EN
      pend_valid_n  = pend_valid;
      pend_load     = 1'b0;
      buf_from_pend = 1'b0;
      outstanding_n = outstanding;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               rate_n = mode ? RATE_256 : RATE_128;
               rem_n  = len_words;
               if (len_words == '0) begin
                  state_n = FIN;
               end else begin
                  state_n    = WAIT_PERM;
                  perm_req_n = 1'b1;
               end
            end
         end
         WAIT_PERM: begin
            if (perm_done) begin
               load_buf = 1'b1;
               idx_n    = 5'd0;
               data_n   = lane_sel(state_in, 5'd0);
               last_n   = (rem == LEN_W'(1));
               state_n  = EMIT;
`ifdef KECCAK_SQZ_PREFETCH_EN
               outstanding_n = 1'b0;
               if (rem > LEN_W'(rate)) perm_req_n = 1'b1;
`endif
            end
         end
         EMIT: begin
`ifdef KECCAK_SQZ_PREFETCH_EN
            // A prefetched state landing mid-block is parked in pend_buf.
            if (perm_done && outstanding) begin
               pend_load     = 1'b1;
               pend_valid_n  = 1'b1;
               outstanding_n = 1'b0;
            end
`endif
            if (out_ready) begin
               rem_n = rem_dec;
               idx_n = idx_inc;
               if (rem_dec == '0) begin
                  state_n = FIN;
                  data_n  = '0;
                  last_n  = 1'b0;
               end else if (idx_inc == rate) begin
`ifdef KECCAK_SQZ_PREFETCH_EN
                  // Block boundary: switch straight to the prefetched state if
                  // it is here (parked or arriving this cycle), else wait.
                  if (pend_valid || (perm_done && outstanding)) begin
                     load_buf      = 1'b1;
                     buf_from_pend = pend_valid;
                     pend_load     = 1'b0;
                     pend_valid_n  = 1'b0;
                     idx_n         = 5'd0;
                     data_n        = pend_valid ? lane_sel(pend_buf, 5'd0)
                                                : lane_sel(state_in, 5'd0);
                     last_n        = (rem_dec == LEN_W'(1));
                     if (rem_dec > LEN_W'(rate)) perm_req_n = 1'b1;
                  end else begin
                     state_n = WAIT_PERM;
                     data_n  = '0;
                     last_n  = 1'b0;
                  end
`else
                  perm_req_n = 1'b1;
                  state_n    = WAIT_PERM;
                  data_n     = '0;
                  last_n     = 1'b0;
`endif
               end else begin
                  data_n = lane_sel(state_buf, idx_inc);
                  last_n = (rem_dec == LEN_W'(1));
               end
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
`ifdef KECCAK_SQZ_PREFETCH_EN
      if (perm_req_n) outstanding_n = 1'b1;
`endif
   end

   // Datapath registers: counters, registered outputs and the capture buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rate      <= 5'd0;
         rem       <= '0;
         idx       <= 5'd0;
         perm_req  <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         state_buf <= '0;
      end else begin
         rate     <= rate_n;
         rem      <= rem_n;
         idx      <= idx_n;
         perm_req <= perm_req_n;
         out_data <= data_n;
         out_last <= last_n;
`ifdef KECCAK_SQZ_PREFETCH_EN
         if (load_buf) state_buf <= buf_from_pend ? pend_buf : state_in;
`else
         if (load_buf) state_buf <= state_in;
`endif
      end
   end

`ifdef KECCAK_SQZ_PREFETCH_EN
   // Pending buffer and request tracking for the prefetch path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_buf    <= '0;
         pend_valid  <= 1'b0;
         outstanding <= 1'b0;
      end else begin
         if (pend_load) pend_buf <= state_in;
         pend_valid  <= pend_valid_n;
         outstanding <= outstanding_n;
      end
   end
`endif

endmodule
